// File: rtl/column_compress_iter.sv
// Iterative carry-save reducer: ROWS partial-product rows are folded to a sum/carry pair,
// one 6:3 compression pass per clock, all arithmetic mod 2^WIDTH.
//
// state    | meaning
// S_IDLE   | waiting for a job; in_ready high
// S_REDUCE | one compression pass per edge, then one edge to settle into S_DONE
// S_DONE   | result on out_sum/out_carry, held until out_ready
module column_compress_iter #(
    parameter int WIDTH = 32,
    parameter int ROWS  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*WIDTH-1:0] in_rows,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_sum,
    output logic [WIDTH-1:0]      out_carry,
    output logic                  busy
);

    function automatic int calc_passes(input int rows);
        int n;
        int p;
        n = rows;
        p = 0;
        while (n > 2) begin
            if (n > 3) n = 3 * ((n + 5) / 6);
            else       n = 2;
            p++;
        end
        return p;
    endfunction

    localparam int NUM_PASSES = calc_passes(ROWS);
    localparam int NG         = (ROWS + 5) / 6;
    localparam int CW         = $clog2(NUM_PASSES + 1);
    localparam logic [CW-1:0] LAST_PASS = CW'(NUM_PASSES);

    if (ROWS < 3) begin : g_bad_rows
        $error("column_compress_iter: ROWS must be >= 3");
    end

    typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_pass_cnt;
    logic [WIDTH-1:0] r_rows      [ROWS];
    logic [WIDTH-1:0] w_pad       [6*NG];
    logic [WIDTH-1:0] w_pass_rows [ROWS];

    // Zero-pad the row store to a whole number of 6-row groups.
    for (genvar r = 0; r < 6 * NG; r++) begin : g_pad
        if (r < ROWS) begin : g_row
            assign w_pad[r] = r_rows[r];
        end else begin : g_zero
            assign w_pad[r] = '0;
        end
    end

    always_comb begin
        logic [2:0]       w_cnt;
        logic [WIDTH-1:0] w_b0;
        logic [WIDTH-1:0] w_b1;
        logic [WIDTH-1:0] w_b2;
        for (int r = 0; r < ROWS; r++) w_pass_rows[r] = '0;
        for (int g = 0; g < NG; g++) begin
            w_b0 = '0;
            w_b1 = '0;
            w_b2 = '0;
            for (int i = 0; i < WIDTH; i++) begin
                w_cnt = '0;
                for (int j = 0; j < 6; j++) w_cnt = w_cnt + {2'b00, w_pad[6*g+j][i]};
                w_b0[i] = w_cnt[0];
                w_b1[i] = w_cnt[1];
                w_b2[i] = w_cnt[2];
            end
            // Shifts drop weights >= 2^WIDTH and leave the low bits of rows B/C zero.
            w_pass_rows[3*g]   = w_b0;
            w_pass_rows[3*g+1] = w_b1 << 1;
            w_pass_rows[3*g+2] = w_b2 << 2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pass_cnt <= '0;
            for (int r = 0; r < ROWS; r++) r_rows[r] <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_pass_cnt <= '0;
                        for (int r = 0; r < ROWS; r++) r_rows[r] <= in_rows[r*WIDTH +: WIDTH];
                    end
                end
                S_REDUCE: begin
                    if (r_pass_cnt < LAST_PASS) begin
                        r_pass_cnt <= r_pass_cnt + 1'b1;
                        for (int r = 0; r < ROWS; r++) r_rows[r] <= w_pass_rows[r];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_state_nxt = S_REDUCE;
            S_REDUCE: if (r_pass_cnt == LAST_PASS) w_state_nxt = S_DONE;
            S_DONE:   if (out_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_REDUCE) || (r_state == S_DONE);
    assign out_sum   = r_rows[0];
    assign out_carry = r_rows[1];

endmodule

// File: tb/tb_column_compress_iter.sv
// Scoreboard bench for column_compress_iter: a 12-row and a 16-row instance, directed
// corner jobs on the 12-row one, then random jobs with random handshake gaps on both.
module tb_column_compress_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [2];
    logic        ir   [2];
    logic        ov   [2];
    logic        ordy [2];
    logic        bsy  [2];
    logic [31:0] os   [2];
    logic [31:0] oc   [2];
    logic [12*32-1:0] rows12;
    logic [16*32-1:0] rows16;

    int n_tests = 0;
    int n_fail  = 0;
    bit rnd     = 1'b0;
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    always #5 clk = ~clk;

    column_compress_iter #(.WIDTH(32), .ROWS(12)) u_dut12 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_rows(rows12),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(os[0]), .out_carry(oc[0]),
        .busy(bsy[0])
    );

    column_compress_iter #(.WIDTH(32), .ROWS(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_rows(rows16),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(os[1]), .out_carry(oc[1]),
        .busy(bsy[1])
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Offers one job; the expected modular sum is queued once the accept is certain.
    task automatic drive_job(input int k, input logic [31:0] r [16]);
        logic [31:0] s;
        int nr;
        int w;
        nr = (k == 0) ? 12 : 16;
        s  = '0;
        for (int i = 0; i < nr; i++) s = s + r[i];
        @(negedge clk);
        if (k == 0) for (int i = 0; i < 12; i++) rows12[i*32 +: 32] = r[i];
        else        for (int i = 0; i < 16; i++) rows16[i*32 +: 32] = r[i];
        iv[k] = 1'b1;
        w = 0;
        while (!ir[k] && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!ir[k]) check("accept_timeout", {63'b0, ir[k]}, 64'd1);
        else if (k == 0) exp_q0.push_back(s);
        else exp_q1.push_back(s);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (!ov[k] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", {63'b0, ov[k]}, 64'd1);
    endtask

    // Drives a job with out_ready already high and measures accept-to-out_valid edges.
    task automatic run_lat(input int k, input logic [31:0] r [16], input int exp_lat);
        int lat;
        drive_job(k, r);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                check("busy_reduce", {63'b0, bsy[k]}, 64'd1);
                check("in_ready_reduce", {63'b0, ir[k]}, 64'd0);
            end
        end while (!ov[k] && lat < 30);
        check("latency", 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
        check("in_ready_after_hs", {63'b0, ir[k]}, 64'd1);
        check("out_valid_after_hs", {63'b0, ov[k]}, 64'd0);
    endtask

    // Scoreboard side: compares at the negedge before each output handshake edge.
    initial begin
        logic [31:0] act;
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rnd) ordy[k] = 1'($urandom_range(0, 1));
                if (ov[k] && ordy[k] && !rst) begin
                    act = os[k] + oc[k];
                    if (k == 0) begin
                        if (exp_q0.size() == 0) check("sb_nonempty12", 64'(exp_q0.size()), 64'd1);
                        else begin
                            exp = exp_q0.pop_front();
                            check("modsum12", 64'(act), 64'(exp));
                        end
                    end else begin
                        if (exp_q1.size() == 0) check("sb_nonempty16", 64'(exp_q1.size()), 64'd1);
                        else begin
                            exp = exp_q1.pop_front();
                            check("modsum16", 64'(act), 64'(exp));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] rr  [16];
    logic [31:0] rr0 [16];
    logic [31:0] rr1 [16];

    initial begin
        logic [31:0] cap_s;
        logic [31:0] cap_c;
        bit          seen;
        int          w;

        rst    = 1'b1;
        rows12 = '0;
        rows16 = '0;
        for (int k = 0; k < 2; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", {63'b0, ov[0]}, 64'd0);
        check("rst_busy", {63'b0, bsy[0]}, 64'd0);
        check("rst_out_sum", 64'(os[0]), 64'd0);
        check("rst_out_carry", 64'(oc[0]), 64'd0);
        check("rst_in_ready", {63'b0, ir[0]}, 64'd1);

        // Corner patterns, out_ready held high throughout.
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        for (int i = 0; i < 16; i++) rr[i] = 32'h0;
        run_lat(0, rr, 4);
        for (int i = 0; i < 16; i++) rr[i] = 32'hFFFF_FFFF;
        run_lat(0, rr, 4);
        for (int i = 0; i < 16; i++) rr[i] = 32'h8000_0000;
        run_lat(0, rr, 4);
        for (int i = 0; i < 16; i++) rr[i] = 32'h0;
        rr[0] = 32'h1;
        run_lat(0, rr, 4);
        for (int i = 0; i < 16; i++) rr[i] = 32'hFFFF_FFFF;
        run_lat(1, rr, 5);

        // Back-pressure in DONE with ignored in_valid pulses.
        for (int i = 0; i < 16; i++) rr[i] = $urandom;
        ordy[0] = 1'b0;
        drive_job(0, rr);
        wait_done(0);
        cap_s = os[0];
        cap_c = oc[0];
        for (int cy = 0; cy < 10; cy++) begin
            @(posedge clk);
            #1;
            iv[0] = 1'(cy % 2);
            rows12 = {12{$urandom}};
            check("hold_valid", {63'b0, ov[0]}, 64'd1);
            check("hold_sum", 64'(os[0]), 64'(cap_s));
            check("hold_carry", 64'(oc[0]), 64'(cap_c));
            check("hold_in_ready", {63'b0, ir[0]}, 64'd0);
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_ready", {63'b0, ir[0]}, 64'd1);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ov[0] || bsy[0]) seen = 1'b1;
        end
        check("no_ghost_job", {63'b0, seen}, 64'd0);

        // Reset two edges into REDUCE aborts the job.
        for (int i = 0; i < 16; i++) rr[i] = $urandom;
        drive_job(0, rr);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q0.pop_back());
        check("abort_in_ready", {63'b0, ir[0]}, 64'd1);
        check("abort_busy", {63'b0, bsy[0]}, 64'd0);
        check("abort_sum", 64'(os[0]), 64'd0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ov[0]) seen = 1'b1;
        end
        check("abort_no_output", {63'b0, seen}, 64'd0);
        for (int i = 0; i < 16; i++) rr[i] = $urandom;
        run_lat(0, rr, 4);

        // Random jobs on both widths with random gaps and random out_ready.
        rnd = 1'b1;
        fork
            begin
                repeat (1000) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    for (int i = 0; i < 16; i++)
                        rr0[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    drive_job(0, rr0);
                end
            end
            begin
                repeat (1000) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    for (int i = 0; i < 16; i++)
                        rr1[i] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                    drive_job(1, rr1);
                end
            end
        join
        w = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain12", 64'(exp_q0.size()), 64'd0);
        check("drain16", 64'(exp_q1.size()), 64'd0);
        rnd = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
